test_stream_checker: RTL and testbench



---
 rtl/test_stream_checker.sv | 196 +++++++++++++++++++
 tb/tb_test_stream_checker.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_stream_checker.sv
// Test-pattern stream checker: locks onto 16-byte block framing and verifies sync
// bits, the counter sequence and the per-block checksum in a two-stage pipeline.
module test_stream_checker #(
  parameter int LOSS_BLOCKS = 2,
  parameter int ERR_W       = 16
) (
  input  logic             ifclk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [31:0]      DI,
  input  logic             DI_valid,
  output logic             DI_ready,
  output logic             locked,
  output logic             block_ok,
  output logic             block_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [31:0]      word_cnt
);

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam int              BR_W   = $clog2(LOSS_BLOCKS + 1);
  localparam logic [BR_W-1:0] LOSS_V = BR_W'(LOSS_BLOCKS);

  state_t            state_reg, state_next;
  logic [1:0]        word_pos_reg, word_pos_next;
  logic [6:0]        exp_cnt_reg, exp_cnt_next;
  logic              ready_reg, ready_next;
  logic              s1_valid_reg, s1_valid_next;
  logic [31:0]       s1_data_reg, s1_data_next;
  logic              s1_err_reg, s1_err_next;
  logic [1:0]        s1_pos_reg, s1_pos_next;
  logic [13:0]       cs_reg, cs_next;
  logic              any_err_reg, any_err_next;
  logic [BR_W-1:0]   bad_run_reg, bad_run_next;
  logic [ERR_W-1:0]  err_cnt_reg, err_cnt_next;
  logic [31:0]       word_cnt_reg, word_cnt_next;
  logic              block_ok_reg, block_ok_next;
  logic              block_err_reg, block_err_next;

  logic              accept;
  logic              sync_hit;
  logic [6:0]        lane_exp [4];
  logic [3:0]        lane_p [4];
  logic [3:0]        lane_err;
  logic [9:0]        byte_sum;
  logic [13:0]       cs_new;
  logic              cs_err;
  logic              blk_err;
  logic              blk_end;
  logic [BR_W-1:0]   bad_run_inc;
  logic              drop;

  assign accept   = DI_valid && ready_reg;
  // Word carrying positions 12..15 is the only one with lane syncs {0,1,1,1}.
  assign sync_hit = ({DI[31], DI[23], DI[15], DI[7]} == 4'b1110);

  // Stage-1 per-lane compare against expected sync and counter.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_p[gi]   = {word_pos_reg, 2'(gi)};
    assign lane_exp[gi] = exp_cnt_reg + 7'(111 * gi);
    assign lane_err[gi] = (DI[8*gi+7] != (lane_p[gi][0] || (lane_p[gi] == 4'd14)))
                       || ((lane_p[gi] != 4'd15) && (DI[8*gi+6 -: 7] != lane_exp[gi]));
  end

  // Stage-2 checksum accumulation; byte 15 is excluded from the sum.
  always_comb begin
    byte_sum = 10'(s1_data_reg[7:0]) + 10'(s1_data_reg[15:8]) + 10'(s1_data_reg[23:16]);
    if (s1_pos_reg != 2'd3) begin
      byte_sum = byte_sum + 10'(s1_data_reg[31:24]);
    end
    cs_new      = ((s1_pos_reg == 2'd0) ? 14'd47 : cs_reg) + 14'(byte_sum);
    cs_err      = (s1_pos_reg == 2'd3) && (s1_data_reg[30:24] != (cs_new[6:0] ^ cs_new[13:7]));
    blk_err     = s1_err_reg || cs_err || ((s1_pos_reg != 2'd0) && any_err_reg);
    blk_end     = s1_valid_reg && (s1_pos_reg == 2'd3);
    bad_run_inc = bad_run_reg + 1'b1;
    drop        = blk_end && blk_err && (bad_run_inc == LOSS_V);
  end

  always_comb begin
    state_next     = state_reg;
    word_pos_next  = word_pos_reg;
    exp_cnt_next   = exp_cnt_reg;
    ready_next     = enable && !clear;
    s1_valid_next  = 1'b0;
    s1_data_next   = s1_data_reg;
    s1_err_next    = s1_err_reg;
    s1_pos_next    = s1_pos_reg;
    cs_next        = cs_reg;
    any_err_next   = any_err_reg;
    bad_run_next   = bad_run_reg;
    err_cnt_next   = err_cnt_reg;
    word_cnt_next  = word_cnt_reg;
    block_ok_next  = 1'b0;
    block_err_next = 1'b0;

    if (clear) begin
      state_next    = HUNT;
      word_pos_next = 2'd0;
      exp_cnt_next  = 7'd0;
      cs_next       = 14'd0;
      any_err_next  = 1'b0;
      bad_run_next  = '0;
      err_cnt_next  = '0;
      word_cnt_next = 32'd0;
    end else begin
      if (s1_valid_reg) begin
        cs_next       = cs_new;
        any_err_next  = blk_err;
        word_cnt_next = word_cnt_reg + 32'd1;
        if (blk_end) begin
          block_ok_next  = !blk_err;
          block_err_next = blk_err;
          if (blk_err) begin
            if (err_cnt_reg != {ERR_W{1'b1}}) begin
              err_cnt_next = err_cnt_reg + 1'b1;
            end
            bad_run_next = drop ? '0 : bad_run_inc;
          end else begin
            bad_run_next = '0;
          end
        end
      end

      // Losing lock discards a word accepted in the same cycle.
      if (drop) begin
        state_next = HUNT;
      end else if (accept) begin
        case (state_reg)
          HUNT: begin
            if (sync_hit) begin
              state_next    = LOCKED;
              word_pos_next = 2'd0;
              exp_cnt_next  = DI[22:16] + 7'd111;
            end
          end
          LOCKED: begin
            s1_valid_next = 1'b1;
            s1_data_next  = DI;
            s1_err_next   = |lane_err;
            s1_pos_next   = word_pos_reg;
            word_pos_next = word_pos_reg + 2'd1;
            exp_cnt_next  = (word_pos_reg == 2'd3) ? exp_cnt_reg + 7'(3 * 111)
                                                   : exp_cnt_reg + 7'(4 * 111);
          end
          default: state_next = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= HUNT;
      word_pos_reg  <= 2'd0;
      exp_cnt_reg   <= 7'd0;
      ready_reg     <= 1'b0;
      s1_valid_reg  <= 1'b0;
      s1_data_reg   <= 32'd0;
      s1_err_reg    <= 1'b0;
      s1_pos_reg    <= 2'd0;
      cs_reg        <= 14'd0;
      any_err_reg   <= 1'b0;
      bad_run_reg   <= '0;
      err_cnt_reg   <= '0;
      word_cnt_reg  <= 32'd0;
      block_ok_reg  <= 1'b0;
      block_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      word_pos_reg  <= word_pos_next;
      exp_cnt_reg   <= exp_cnt_next;
      ready_reg     <= ready_next;
      s1_valid_reg  <= s1_valid_next;
      s1_data_reg   <= s1_data_next;
      s1_err_reg    <= s1_err_next;
      s1_pos_reg    <= s1_pos_next;
      cs_reg        <= cs_next;
      any_err_reg   <= any_err_next;
      bad_run_reg   <= bad_run_next;
      err_cnt_reg   <= err_cnt_next;
      word_cnt_reg  <= word_cnt_next;
      block_ok_reg  <= block_ok_next;
      block_err_reg <= block_err_next;
    end
  end

  assign DI_ready  = ready_reg;
  assign locked    = (state_reg == LOCKED);
  assign block_ok  = block_ok_reg;
  assign block_err = block_err_reg;
  assign err_cnt   = err_cnt_reg;
  assign word_cnt  = word_cnt_reg;

endmodule

// File: tb/tb_test_stream_checker.sv
// Scoreboard bench for test_stream_checker: a pattern generator drives blocks, a
// block-level lock model pushes expected results, a monitor pops them on each pulse.
`timescale 1ns/1ps
module tb_test_stream_checker;
  localparam int LOSS    = 2;
  localparam int EW      = 4;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic          ifclk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [31:0]   DI = 32'd0;
  logic          DI_valid = 1'b0;
  logic          DI_ready;
  logic          locked;
  logic          block_ok;
  logic          block_err;
  logic [EW-1:0] err_cnt;
  logic [31:0]   word_cnt;

  always #5 ifclk = ~ifclk;

  test_stream_checker #(.LOSS_BLOCKS(LOSS), .ERR_W(EW)) dut (
    .ifclk(ifclk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .DI(DI), .DI_valid(DI_valid), .DI_ready(DI_ready), .locked(locked),
    .block_ok(block_ok), .block_err(block_err), .err_cnt(err_cnt), .word_cnt(word_cnt)
  );

  typedef struct { logic err; int ecnt; int wcnt; } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0, n_bad = 0, n_ok_seen = 0, n_err_seen = 0, n_blk = 0;
  logic [6:0] gen_cnt = 7'd0;
  logic [7:0] blk_bytes [16];
  bit m_locked = 1'b0;
  int m_bad_run = 0, m_err_cnt = 0, m_word_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Generator: 15 counter bytes stepping by 111, then the folded checksum byte.
  task automatic build_block(input int flip_byte, input int flip_bit);
    logic [13:0] cs;
    logic sync;
    cs = 14'd47;
    for (int p = 0; p < 16; p++) begin
      sync = (p % 2 == 1) || (p == 14);
      if (p < 15) begin
        blk_bytes[p] = {sync, gen_cnt};
        cs = cs + 14'(blk_bytes[p]);
        gen_cnt = gen_cnt + 7'd111;
      end else begin
        blk_bytes[p] = {1'b1, cs[6:0] ^ cs[13:7]};
      end
    end
    if (flip_byte >= 0) blk_bytes[flip_byte][flip_bit] = ~blk_bytes[flip_byte][flip_bit];
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    bit done;
    int guard;
    done = 1'b0;
    guard = 0;
    while (!done) begin
      @(negedge ifclk);
      if (gaps && ($urandom_range(0, 1) == 0)) DI_valid = 1'b0;
      else begin
        DI = w;
        DI_valid = 1'b1;
      end
      if (gaps) enable = ($urandom_range(0, 3) != 0);
      done = DI_valid && DI_ready;
      @(posedge ifclk);
      guard++;
      if (!done && guard > 200) begin
        check_val("accept_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
  endtask

  task automatic send_block(input int fb, input int fbit, input bit gaps);
    exp_t e;
    build_block(fb, fbit);
    if (!m_locked) begin
      m_locked = 1'b1;
    end else begin
      m_word_cnt += 4;
      e.err = (fb >= 0);
      if (e.err) begin
        if (m_err_cnt < ERR_MAX) m_err_cnt++;
        m_bad_run++;
        if (m_bad_run == LOSS) begin
          m_locked = 1'b0;
          m_bad_run = 0;
        end
      end else begin
        m_bad_run = 0;
      end
      e.ecnt = m_err_cnt;
      e.wcnt = m_word_cnt;
      sb_q.push_back(e);
    end
    for (int w = 0; w < 4; w++)
      send_word({blk_bytes[4*w+3], blk_bytes[4*w+2], blk_bytes[4*w+1], blk_bytes[4*w]}, gaps);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge ifclk);
      DI_valid = 1'b0;
    end
  endtask

  task automatic do_clear();
    @(negedge ifclk);
    DI_valid = 1'b0;
    clear = 1'b1;
    @(negedge ifclk);
    clear = 1'b0;
    m_locked = 1'b0;
    m_bad_run = 0;
    m_err_cnt = 0;
    m_word_cnt = 0;
    n_ok_seen = 0;
    n_err_seen = 0;
  endtask

  always @(negedge ifclk) begin
    exp_t e;
    if (reset_n && (block_ok || block_err)) begin
      n_blk++;
      if (sb_q.size() == 0) begin
        check_val("pulse_unexpected", {30'd0, block_ok, block_err}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        $display("blk %0d: %s err_cnt=%0d word_cnt=%0d", n_blk, block_err ? "err" : "ok",
                 err_cnt, word_cnt);
        check_val("block_err", 32'(block_err), 32'(e.err));
        check_val("block_ok", 32'(block_ok), 32'(!e.err));
        check_val("err_cnt_at_pulse", 32'(err_cnt), e.ecnt);
        check_val("word_cnt_at_pulse", word_cnt, e.wcnt);
      end
      if (block_ok) n_ok_seen++;
      if (block_err) n_err_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbad;
    #12;
    check_val("rst_ready", 32'(DI_ready), 32'd0);
    check_val("rst_locked", 32'(locked), 32'd0);
    check_val("rst_ok", 32'(block_ok), 32'd0);
    check_val("rst_err_cnt", 32'(err_cnt), 32'd0);
    check_val("rst_word_cnt", word_cnt, 32'd0);
    @(negedge ifclk);
    reset_n = 1'b1;
    enable = 1'b1;
    idle(2);

    // Clean stream
    send_block(-1, 0, 1'b0);
    idle(1);
    check_val("lock_first", 32'(locked), 32'd1);
    repeat (63) send_block(-1, 0, 1'b0);
    idle(6);
    check_val("clean_ok_cnt", n_ok_seen, 32'd63);
    check_val("clean_err_seen", n_err_seen, 32'd0);
    check_val("clean_err_cnt", 32'(err_cnt), 32'd0);
    check_val("clean_word_cnt", word_cnt, 32'd252);
    check_val("clean_locked", 32'(locked), 32'd1);
    check_val("clean_drained", sb_q.size(), 32'd0);

    // Single bit flip in byte 5
    do_clear();
    send_block(-1, 0, 1'b0);
    repeat (2) send_block(-1, 0, 1'b0);
    send_block(5, 0, 1'b0);
    repeat (2) send_block(-1, 0, 1'b0);
    idle(6);
    check_val("flip_err_seen", n_err_seen, 32'd1);
    check_val("flip_ok_seen", n_ok_seen, 32'd4);
    check_val("flip_err_cnt", 32'(err_cnt), 32'd1);
    check_val("flip_locked", 32'(locked), 32'd1);

    // Checksum byte corruption
    do_clear();
    send_block(-1, 0, 1'b0);
    send_block(-1, 0, 1'b0);
    send_block(15, 3, 1'b0);
    send_block(-1, 0, 1'b0);
    idle(6);
    check_val("cs_err_seen", n_err_seen, 32'd1);
    check_val("cs_err_cnt", 32'(err_cnt), 32'd1);
    check_val("cs_locked", 32'(locked), 32'd1);

    // Loss of lock and re-lock
    do_clear();
    send_block(-1, 0, 1'b0);
    send_block(-1, 0, 1'b0);
    send_block(5, 0, 1'b0);
    send_block(5, 0, 1'b0);
    idle(4);
    check_val("loss_unlocked", 32'(locked), 32'd0);
    send_block(-1, 0, 1'b0);
    send_block(-1, 0, 1'b0);
    idle(6);
    check_val("loss_relocked", 32'(locked), 32'd1);
    check_val("loss_err_cnt", 32'(err_cnt), 32'd2);
    check_val("loss_err_seen", n_err_seen, 32'd2);

    // Gaps and enable toggling
    do_clear();
    repeat (64) send_block(-1, 0, 1'b1);
    @(negedge ifclk);
    DI_valid = 1'b0;
    enable = 1'b1;
    idle(6);
    check_val("gap_ok_cnt", n_ok_seen, 32'd63);
    check_val("gap_err_seen", n_err_seen, 32'd0);
    check_val("gap_word_cnt", word_cnt, 32'd252);
    check_val("gap_locked", 32'(locked), 32'd1);

    // Saturation, then clear
    do_clear();
    nbad = 0;
    while (nbad < 20) begin
      if (m_locked) nbad++;
      send_block(5, 0, 1'b0);
    end
    send_block(-1, 0, 1'b0);
    idle(6);
    check_val("sat_err_cnt", 32'(err_cnt), 32'(ERR_MAX));
    check_val("sat_err_seen", n_err_seen, 32'd20);
    check_val("sat_locked", 32'(locked), 32'd1);
    do_clear();
    check_val("clr_err_cnt", 32'(err_cnt), 32'd0);
    check_val("clr_word_cnt", word_cnt, 32'd0);
    check_val("clr_locked", 32'(locked), 32'd0);
    check_val("clr_ready", 32'(DI_ready), 32'd0);

    // Asynchronous reset mid-block
    idle(2);
    repeat (3) send_block(-1, 0, 1'b0);
    idle(4);
    check_val("pre_rst_word_cnt", word_cnt, 32'd8);
    build_block(-1, 0);
    send_word({blk_bytes[3], blk_bytes[2], blk_bytes[1], blk_bytes[0]}, 1'b0);
    send_word({blk_bytes[7], blk_bytes[6], blk_bytes[5], blk_bytes[4]}, 1'b0);
    @(negedge ifclk);
    DI_valid = 1'b0;
    check_val("pre_rst_locked", 32'(locked), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_val("arst_ready", 32'(DI_ready), 32'd0);
    check_val("arst_locked", 32'(locked), 32'd0);
    check_val("arst_ok", 32'(block_ok), 32'd0);
    check_val("arst_err", 32'(block_err), 32'd0);
    check_val("arst_err_cnt", 32'(err_cnt), 32'd0);
    check_val("arst_word_cnt", word_cnt, 32'd0);
    @(negedge ifclk);
    reset_n = 1'b1;
    idle(2);
    check_val("final_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
